// File: rtl/acq_pkg.sv
// Shared definitions for the AES debug acquisition path: capture FSM states,
// default probe geometry and a constant-foldable clog2.
package acq_pkg;

    localparam int ACQ_DATA_W      = 32;
    localparam int ACQ_DEPTH       = 256;
    localparam int ACQ_PRE_SAMPLES = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST,
        DONE
    } acq_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one synchronous write port, one registered
// read port, no reset so it maps onto a single M10K-style block RAM.
module capture_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              acq_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and read register are deliberately left out of any reset;
    // a reset term here would stop the tools inferring block RAM. Non-blocking
    // assignments keep read-before-write ordering identical in sim and silicon.
    always_ff @(posedge acq_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Post-trigger acquisition: records a DEPTH-sample probe window around the first
// accepted trigger, with PRE_SAMPLES of guaranteed history, for HPS readback.
module trigger_capture_buffer
    import acq_pkg::*;
#(
    parameter int  DATA_W      = ACQ_DATA_W,
    parameter int  DEPTH       = ACQ_DEPTH,
    parameter int  PRE_SAMPLES = ACQ_PRE_SAMPLES,
    localparam int ADDR_W      = clog2(DEPTH)
) (
    input  logic              acq_clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              trig_in,
    input  logic [DATA_W-1:0] probe_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_pos,
    output logic [ADDR_W-1:0] start_addr
);

    localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRE_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] PRE_OFFSET = ADDR_W'(PRE_SAMPLES);
    localparam logic [ADDR_W-1:0] POST_INIT  = ADDR_W'(DEPTH - PRE_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    acq_state_e        state, state_next;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
    logic [ADDR_W-1:0] pre_cnt, pre_cnt_next;
    logic [ADDR_W-1:0] post_cnt, post_cnt_next;
    logic [ADDR_W-1:0] trig_pos_q, trig_pos_next;
    logic              wr_en;

    always_ff @(posedge acq_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_pos_q <= '0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            pre_cnt    <= pre_cnt_next;
            post_cnt   <= post_cnt_next;
            trig_pos_q <= trig_pos_next;
        end
    end

    // NOTE: every signal gets its hold value before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        wr_ptr_next   = wr_ptr;
        pre_cnt_next  = pre_cnt;
        post_cnt_next = post_cnt;
        trig_pos_next = trig_pos_q;
        wr_en         = 1'b0;

        // arm outranks everything, including a coincident trigger
        if (arm) begin
            state_next   = PRE_FILL;
            wr_ptr_next  = '0;
            pre_cnt_next = '0;
        end else begin
            case (state)
                PRE_FILL: begin
                    wr_en        = 1'b1;
                    wr_ptr_next  = wr_ptr + ONE;
                    pre_cnt_next = pre_cnt + ONE;
                    if (pre_cnt == PRE_LAST) begin
                        state_next = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr + ONE;
                    if (trig_in) begin
                        trig_pos_next = wr_ptr;
                        post_cnt_next = POST_INIT;
                        state_next    = POST;
                    end
                end
                POST: begin
                    wr_en         = 1'b1;
                    wr_ptr_next   = wr_ptr + ONE;
                    post_cnt_next = post_cnt - ONE;
                    if (post_cnt == ONE) begin
                        state_next = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = state inside {PRE_FILL, WAIT_TRIG, POST};
    assign triggered  = state inside {POST, DONE};
    assign done       = (state == DONE);
    assign trig_pos   = trig_pos_q;
    assign start_addr = trig_pos_q - PRE_OFFSET;

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_capture_ram (
        .acq_clk (acq_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (probe_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
